// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter with a transmit FIFO and gap-free back-to-back frames
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tx_start,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BAUD_DIV + 1);

    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || BAUD_DIV < 1) begin : g_bad_params
        $error("uart_tx_fifo: parameter out of range");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state, state_n;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [BW-1:0]        baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit, tx_n, pop, wr_ok, wrap;

    assign tx_ready = fifo_count != CW'(FIFO_DEPTH);
    assign wr_ok    = tx_start && tx_ready;
    assign wrap     = baud_cnt == BW'(BAUD_DIV - 1);
    assign tx_busy  = state != IDLE || fifo_count != '0;

    // next state, pop request and next serial level
    always_comb begin
        state_n = state;
        tx_n    = tx;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    state_n = START;
                    tx_n    = 1'b0;
                end
            end
            START: if (wrap) begin
                state_n = DATA;
                tx_n    = shreg[0];
            end
            DATA: if (wrap) begin
                if (bit_cnt == 4'(DATA_BITS - 1)) begin
                    state_n = PARITY != 0 ? PAR : STOP;
                    tx_n    = PARITY != 0 ? par_bit : 1'b1;
                end else begin
                    tx_n = shreg[1];
                end
            end
            PAR: if (wrap) begin
                state_n = STOP;
                tx_n    = 1'b1;
            end
            STOP: if (wrap && bit_cnt == 4'(STOP_BITS - 1)) begin
                pop     = fifo_count != '0;
                state_n = fifo_count != '0 ? START : IDLE;
                tx_n    = fifo_count == '0;
            end
            default: state_n = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // FIFO bookkeeping, baud/bit timing, shift register and registered line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx         <= 1'b1;
            overflow   <= 1'b0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
        end else begin
            tx         <= tx_n;
            overflow   <= tx_start && !tx_ready;
            fifo_count <= fifo_count + CW'(wr_ok) - CW'(pop);
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            baud_cnt <= (state == IDLE || pop || wrap) ? '0 : baud_cnt + 1'b1;
            if (wrap) bit_cnt <= state_n != state ? '0 : bit_cnt + 1'b1;
            if (pop) begin
                shreg   <= mem[rd_ptr];
                par_bit <= (^mem[rd_ptr]) ^ 1'(PARITY == 2);
            end else if (state == DATA && wrap) begin
                shreg <= shreg >> 1;
            end
        end
    end

    // FIFO storage, contents need no reset
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= tx_data;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized self-checking bench comparing the serial line against a frame-level model
module tb_uart_tx_fifo;
    localparam int BD   = 10;
    localparam int FLEN = (1 + 8 + 1) * BD;
    localparam int PLEN = (1 + 7 + 1 + 2) * BD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_ready, tx, tx_busy, overflow;
    logic [2:0] fifo_count;
    logic       start7 = 1'b0;
    logic [6:0] data7 = '0;
    logic       ready_e, tx_e, busy_e, ovf_e, ready_o, tx_o, busy_o, ovf_o;
    logic [2:0] count_e, count_o;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000)) dut (
        .clk(clk), .reset(rst), .tx_start(tx_start), .tx_data(tx_data), .tx_ready(tx_ready),
        .tx(tx), .tx_busy(tx_busy), .fifo_count(fifo_count), .overflow(overflow));

    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_e (
        .clk(clk), .reset(rst), .tx_start(start7), .tx_data(data7), .tx_ready(ready_e),
        .tx(tx_e), .tx_busy(busy_e), .fifo_count(count_e), .overflow(ovf_e));

    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_o (
        .clk(clk), .reset(rst), .tx_start(start7), .tx_data(data7), .tx_ready(ready_o),
        .tx(tx_o), .tx_busy(busy_o), .fifo_count(count_o), .overflow(ovf_o));

    // line level k clocks into a frame carrying d: start, LSB-first data, optional parity, stop
    function automatic logic frame_bit(input int d, input int db, input int par, input int k);
        int b, ones;
        b = k / BD;
        if (b == 0) return 1'b0;
        if (b <= db) return ((d >> (b - 1)) & 1) != 0;
        if (par != 0 && b == db + 1) begin
            ones = 0;
            for (int i = 0; i < db; i++) ones += (d >> i) & 1;
            return ((ones % 2) == 1) ^ (par == 2);
        end
        return 1'b1;
    endfunction

    // line level k clocks after the first start edge of gap-free 8N1 frames from exp_q
    function automatic logic stream_bit(input int k);
        if (k / FLEN >= exp_q.size()) return 1'b1;
        return frame_bit(int'(exp_q[k / FLEN]), 8, 0, k % FLEN);
    endfunction

    task automatic test_reset();
        @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", tx_busy); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", tx_ready); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle got tx=%b busy=%b want 1 0", tx, tx_busy); end
    endtask

    task automatic test_single();
        exp_q = {8'hA5};
        tx_start = 1'b1; tx_data = 8'hA5;
        for (int i = 0; i <= FLEN + 1; i++) begin
            @(negedge clk);
            tx_start = 1'b0;
            if (i == 0) begin
                checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", fifo_count); end
            end
            checks++; if (tx !== (i == 0 ? 1'b1 : stream_bit(i - 1))) begin errors++; $display("FAIL single_tx clk %0d got %b want %b", i, tx, stream_bit(i - 1)); end
            checks++; if (tx_busy !== (i <= FLEN)) begin errors++; $display("FAIL single_busy clk %0d got %b want %b", i, tx_busy, i <= FLEN); end
        end
    endtask

    task automatic test_back_to_back();
        exp_q = {8'hA5, 8'h3C};
        tx_start = 1'b1; tx_data = 8'hA5;
        for (int i = 0; i <= 2 * FLEN + 1; i++) begin
            @(negedge clk);
            tx_data = 8'h3C;
            tx_start = i == 0;
            if (i <= 1) begin
                checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL b2b_count clk %0d got %0d want 1", i, fifo_count); end
            end
            checks++; if (tx !== (i == 0 ? 1'b1 : stream_bit(i - 1))) begin errors++; $display("FAIL b2b_tx clk %0d got %b want %b", i, tx, stream_bit(i - 1)); end
            checks++; if (tx_busy !== (i <= 2 * FLEN)) begin errors++; $display("FAIL b2b_busy clk %0d got %b want %b", i, tx_busy, i <= 2 * FLEN); end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] w[6];
        int c;
        logic acc;
        for (int i = 0; i < 6; i++) w[i] = 8'($urandom);
        exp_q.delete();
        c = 0;
        tx_start = 1'b1; tx_data = w[0];
        for (int i = 0; i <= 5 * FLEN + 1; i++) begin
            @(negedge clk);
            if (i <= 5) begin
                acc = c < 4;
                if (acc) exp_q.push_back(w[i]);
                c = c + int'(acc) - int'(i == 1);
                checks++; if (fifo_count !== 3'(c)) begin errors++; $display("FAIL ovf_count write %0d got %0d want %0d", i, fifo_count, c); end
                checks++; if (tx_ready !== (c != 4)) begin errors++; $display("FAIL ovf_ready write %0d got %b want %b", i, tx_ready, c != 4); end
                checks++; if (overflow !== !acc) begin errors++; $display("FAIL ovf_pulse write %0d got %b want %b", i, overflow, !acc); end
                if (i < 5) tx_data = w[i + 1];
                else tx_start = 1'b0;
            end else if (i == 6) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_pulse_len got %b want 0", overflow); end
            end
            checks++; if (tx !== (i == 0 ? 1'b1 : stream_bit(i - 1))) begin errors++; $display("FAIL ovf_tx clk %0d got %b want %b", i, tx, stream_bit(i - 1)); end
            checks++; if (tx_busy !== (i <= 5 * FLEN)) begin errors++; $display("FAIL ovf_busy clk %0d got %b want %b", i, tx_busy, i <= 5 * FLEN); end
        end
    endtask

    task automatic test_parity();
        logic [6:0] w[2];
        logic ee, eo;
        w[0] = 7'h43;
        w[1] = 7'($urandom);
        start7 = 1'b1; data7 = w[0];
        for (int i = 0; i <= 2 * PLEN + 1; i++) begin
            @(negedge clk);
            data7 = w[1];
            start7 = i == 0;
            ee = 1'b1; eo = 1'b1;
            if (i > 0 && (i - 1) / PLEN < 2) begin
                ee = frame_bit(int'(w[(i - 1) / PLEN]), 7, 1, (i - 1) % PLEN);
                eo = frame_bit(int'(w[(i - 1) / PLEN]), 7, 2, (i - 1) % PLEN);
            end
            if (i == 86) begin
                checks++; if (tx_e !== 1'b1 || tx_o !== 1'b0) begin errors++; $display("FAIL parity_43 got even=%b odd=%b want 1 0", tx_e, tx_o); end
            end
            checks++; if (tx_e !== ee) begin errors++; $display("FAIL even_tx clk %0d got %b want %b", i, tx_e, ee); end
            checks++; if (tx_o !== eo) begin errors++; $display("FAIL odd_tx clk %0d got %b want %b", i, tx_o, eo); end
            checks++; if (busy_e !== (i <= 2 * PLEN)) begin errors++; $display("FAIL even_busy clk %0d got %b want %b", i, busy_e, i <= 2 * PLEN); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] w[3];
        int lows;
        for (int i = 0; i < 3; i++) w[i] = 8'($urandom);
        exp_q = {w[0], w[1], w[2]};
        tx_start = 1'b1; tx_data = w[0];
        for (int i = 0; i <= 45; i++) begin
            @(negedge clk);
            tx_start = i < 2;
            if (i < 2) tx_data = w[i + 1];
            if (i > 0 && i < 45) begin
                checks++; if (tx !== stream_bit(i - 1)) begin errors++; $display("FAIL rst_pre_tx clk %0d got %b want %b", i, tx, stream_bit(i - 1)); end
            end
        end
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL rst_pre_count got %0d want 2", fifo_count); end
        #2 rst = 1'b1;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_mid_tx got %b want 1", tx); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", tx_busy); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_mid_count got %0d want 0", fifo_count); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 3 * FLEN; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) lows++;
        end
        checks++; if (lows !== 0) begin errors++; $display("FAIL rst_no_frame got %0d active clks want 0", lows); end
    endtask

    task automatic test_pop_collision();
        logic [7:0] w[4];
        int n;
        for (int i = 0; i < 4; i++) w[i] = 8'($urandom);
        exp_q = {w[0], w[1], w[2], w[3]};
        n = 1;
        tx_start = 1'b1; tx_data = w[0];
        for (int i = 0; i <= 4 * FLEN + 1; i++) begin
            @(negedge clk);
            tx_start = 1'b0;
            if (i + 1 == 1 || i + 1 == 2 || i + 1 == FLEN + 1) begin
                tx_start = 1'b1;
                tx_data = w[n];
                n++;
            end
            if (i == 2 || i == FLEN || i == FLEN + 1) begin
                checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL coll_count clk %0d got %0d want 2", i, fifo_count); end
            end
            if (i == FLEN + 1) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL coll_ovf got %b want 0", overflow); end
            end
            checks++; if (tx !== (i == 0 ? 1'b1 : stream_bit(i - 1))) begin errors++; $display("FAIL coll_tx clk %0d got %b want %b", i, tx, stream_bit(i - 1)); end
            checks++; if (tx_busy !== (i <= 4 * FLEN)) begin errors++; $display("FAIL coll_busy clk %0d got %b want %b", i, tx_busy, i <= 4 * FLEN); end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        repeat (5) @(negedge clk);
        test_back_to_back();
        repeat (5) @(negedge clk);
        test_overflow();
        repeat (5) @(negedge clk);
        test_parity();
        repeat (5) @(negedge clk);
        test_reset_mid_frame();
        repeat (5) @(negedge clk);
        test_pop_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
